mdu: RTL
========

# mdu

Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file and consumes its two read ports (rs value on `a`, rt value on `b`) for MULT/MULTU/DIV/DIVU. Results are held in HI/LO for later MFHI/MFLO and can be written directly by MTHI/MTLO. The CPU stalls on `busy`.

## Interface
- None. The datapath is fixed at 32 bits and the iteration count is fixed at 32.

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous reset, active low
- `start`  in  1  launch operation `op` on operands `a`, `b`; accepted only when `busy`=0
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `a`  in  32  operand A (rs value from register file)
- `b`  in  32  operand B (rt value from register file)
- `hi_wr`  in  1  MTHI: write `a` into HI
- `lo_wr`  in  1  MTLO: write `a` into LO
- `busy`  out  1  operation in progress
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, iteration counter=0, and any in-flight operation is aborted. Reset takes effect immediately.
- States:
  - IDLE: `start`=1 latches `op`, converts `a`/`b` to magnitudes for signed ops, records the result signs, and moves to RUN.
  - RUN: performs 32 iterations, one per clock, and returns to IDLE on the last one.
- Multiply: shift-add over the 64-bit magnitude product. Signed ops negate the product if the operand signs differ. HI receives the upper 32 bits and LO the lower 32 bits.
- Divide: restoring division, one quotient bit per cycle.
  - LO receives the quotient and HI the remainder.
  - Signed ops truncate toward zero: the quotient is negative iff the operand signs differ, and the remainder takes the sign of `a`.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (`b`=0, any divide op): HI=`a`, LO=0xFFFFFFFF. The op still takes the full 32 cycles.
- `start` while `busy`=1 is ignored.
- `hi_wr`/`lo_wr` while `busy`=1 are ignored.
- `hi_wr`/`lo_wr` in IDLE write `a` at that edge.
  - If `start` is asserted in the same cycle, the write still happens and the later operation result overwrites it.
  - `hi_wr` and `lo_wr` together write `a` to both registers.
- HI/LO change only at a move-to write or at operation completion. Intermediate values are never visible on `hi`/`lo`.

## Timing
- `start` sampled high at edge E0 with `busy`=0: `busy`=1 after E0.
- Iterations occur at edges E1..E32. HI/LO are written and `busy` clears at E32. Results are visible in the cycle after E32.
- Latency is therefore 32 cycles from accept to result; back-to-back throughput is one op per 33 cycles.
- A new `start` may be asserted in the cycle after E32 (`busy`=0).
- Operands are latched at E0. `a`/`b` may change freely during RUN.
- `hi`/`lo`/`busy` are register outputs with no combinational path from inputs.
- Reset asserted during RUN: `busy`=0 immediately, HI/LO=0, no result written. After `rst_n` releases, the first rising edge behaves as IDLE.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `busy` high for exactly 32 cycles.
  - Then HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV cases:
  - a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> HI=100, LO=0xFFFFFFFF after 32 cycles.
- MTHI a=0x12345678 in IDLE -> HI=0x12345678 next cycle. MTLO issued while `busy` -> ignored, LO holds the operation result.
- Start MULTU 5×6:
  - Assert `rst_n`=0 at iteration 10 -> `busy`=0, HI=LO=0 immediately.
  - After reset, start DIVU 17/5 -> LO=3, HI=2.
  - A `start` pulsed mid-operation is ignored (result and timing unchanged).

Source files
------------

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per clock, 32 steps per operation.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] w_q, w_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[31]) ? -a : a;
    assign abs_b     = (signed_op && b[31]) ? -b : b;

    // Work register: multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_diff = w_q[63:31] - {1'b0, opnd_q};

    always_comb begin
        step = w_q;
        if (dz_q) begin
            step = w_q;
        end else if (is_div_q) begin
            step = div_diff[32] ? {w_q[62:0], 1'b0} : {div_diff[31:0], w_q[30:0], 1'b1};
        end else begin
            step = {mul_sum, w_q[31:1]};
        end
    end

    assign prod_fix = neg_q ? -step : step;
    assign quo_fix  = neg_q ? -step[31:0] : step[31:0];
    assign rem_fix  = rem_neg_q ? -step[63:32] : step[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        w_d       = w_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (hi_wr) hi_d = a;
                if (lo_wr) lo_d = a;
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    is_div_d = op[1];
                    dz_d     = op[1] && (b == 32'd0);
                    if (op[1]) begin
                        opnd_d = abs_b;
                        // Divide by zero preloads the architectural result and just idles through the steps.
                        if (b == 32'd0) begin
                            w_d       = {a, 32'hFFFF_FFFF};
                            neg_d     = 1'b0;
                            rem_neg_d = 1'b0;
                        end else begin
                            w_d       = {32'd0, abs_a};
                            neg_d     = signed_op && (a[31] ^ b[31]);
                            rem_neg_d = signed_op && a[31];
                        end
                    end else begin
                        w_d       = {32'd0, abs_b};
                        opnd_d    = abs_a;
                        neg_d     = signed_op && (a[31] ^ b[31]);
                        rem_neg_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                w_d   = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            w_q       <= 64'd0;
            opnd_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            w_q       <= w_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
